// File: rtl/dphy_pkg.sv
// Shared constants and state encoding for the D-PHY lane aligner.
package dphy_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        HUNT,
        LOCKED,
        FAIL
    } align_state_t;

endpackage

// File: rtl/dphy_sync_match.sv
// Combinational sync-byte comparator for one candidate alignment.
// Define DPHY_ALIGN_SYNC_TOL_EN to also accept candidates one bit away from the sync byte.
module dphy_sync_match
    import dphy_pkg::*;
(
    input  logic [7:0] candidate,
    output logic       match
);

`ifdef DPHY_ALIGN_SYNC_TOL_EN
    logic [7:0] diff;

    // Zero or one differing bit: clearing the lowest set bit leaves nothing.
    assign diff  = candidate ^ SYNC_BYTE;
    assign match = ((diff & (diff - 8'd1)) == 8'd0);
`else
    assign match = (candidate == SYNC_BYTE);
`endif

endmodule

// File: rtl/dphy_lane_aligner.sv
// Per-lane D-PHY HS byte aligner: finds the sync byte at either bit phase of the 2-bit DDR stream.
// Sync tolerance is selected by DPHY_ALIGN_SYNC_TOL_EN inside dphy_sync_match.
module dphy_lane_aligner
    import dphy_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       dphy_clk,
    input  logic       areset,
    input  logic [1:0] din,
    input  logic       hs_enable,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       sync_found,
    output logic       aligned,
    output logic       phase,
    output logic       sync_err
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] HUNT_LAST   = TW'(TIMEOUT_CYCLES - 1);

    align_state_t  state_reg, state_next;
    logic [8:0]    sr_reg;
    logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
    logic [TW-1:0] hunt_cnt_reg, hunt_cnt_next;
    logic [1:0]    byte_cnt_reg, byte_cnt_next;
    logic [7:0]    byte_out_reg, byte_out_next;
    logic          byte_valid_reg, byte_valid_next;
    logic          sync_found_reg, sync_found_next;
    logic          aligned_reg, aligned_next;
    logic          phase_reg, phase_next;
    logic          sync_err_reg, sync_err_next;

    // Index 0 is the even alignment (ends on din[1]), index 1 the odd one (ends on din[0]).
    logic [7:0] cand [2];
    logic [1:0] match;

    assign cand[0] = sr_reg[8:1];
    assign cand[1] = sr_reg[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            dphy_sync_match u_match (
                .candidate (cand[gi]),
                .match     (match[gi])
            );
        end
    endgenerate

    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            state_reg      <= IDLE;
            sr_reg         <= '0;
            settle_cnt_reg <= '0;
            hunt_cnt_reg   <= '0;
            byte_cnt_reg   <= '0;
            byte_out_reg   <= '0;
            byte_valid_reg <= 1'b0;
            sync_found_reg <= 1'b0;
            aligned_reg    <= 1'b0;
            phase_reg      <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= {din[1], din[0], sr_reg[8:2]};
            settle_cnt_reg <= settle_cnt_next;
            hunt_cnt_reg   <= hunt_cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            byte_out_reg   <= byte_out_next;
            byte_valid_reg <= byte_valid_next;
            sync_found_reg <= sync_found_next;
            aligned_reg    <= aligned_next;
            phase_reg      <= phase_next;
            sync_err_reg   <= sync_err_next;
        end
    end

    // Dropping hs_enable overrides every other transition.
    always_comb begin
        state_next = state_reg;
        if (!hs_enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = SETTLE;
                SETTLE:  if (settle_cnt_reg == SETTLE_LAST) state_next = HUNT;
                HUNT: begin
                    if (|match)                         state_next = LOCKED;
                    else if (hunt_cnt_reg == HUNT_LAST) state_next = FAIL;
                end
                LOCKED:  state_next = LOCKED;
                FAIL:    state_next = FAIL;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        settle_cnt_next = '0;
        hunt_cnt_next   = '0;
        byte_cnt_next   = '0;
        byte_out_next   = byte_out_reg;
        byte_valid_next = 1'b0;
        sync_found_next = 1'b0;
        sync_err_next   = 1'b0;
        phase_next      = phase_reg;
        aligned_next    = (state_next == LOCKED);
        if (!hs_enable) begin
            phase_next = 1'b0;
        end else begin
            case (state_reg)
                SETTLE: settle_cnt_next = settle_cnt_reg + 1'b1;
                HUNT: begin
                    hunt_cnt_next = (hunt_cnt_reg == HUNT_LAST) ? hunt_cnt_reg : hunt_cnt_reg + 1'b1;
                    if (|match) begin
                        // Even alignment wins when both candidates match.
                        phase_next      = ~match[0];
                        byte_out_next   = SYNC_BYTE;
                        byte_valid_next = 1'b1;
                        sync_found_next = 1'b1;
                    end else if (hunt_cnt_reg == HUNT_LAST) begin
                        sync_err_next = 1'b1;
                    end
                end
                LOCKED: begin
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                    if (byte_cnt_reg == 2'd3) begin
                        byte_out_next   = cand[phase_reg];
                        byte_valid_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_out   = byte_out_reg;
    assign byte_valid = byte_valid_reg;
    assign sync_found = sync_found_reg;
    assign aligned    = aligned_reg;
    assign phase      = phase_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_dphy_lane_aligner.sv
// Directed bench for dphy_lane_aligner with a bit-history reference model checked every cycle.
module tb_dphy_lane_aligner;

    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 64;
    localparam logic [7:0] SYNC   = 8'hB8;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_HUNT   = 2;
    localparam int M_LOCKED = 3;
    localparam int M_STUCK  = 4;

    logic       dphy_clk = 1'b0;
    logic       areset;
    logic [1:0] din;
    logic       hs_enable;
    logic [7:0] byte_out;
    logic       byte_valid, sync_found, aligned, phase, sync_err;

    dphy_lane_aligner #(
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .dphy_clk   (dphy_clk),
        .areset     (areset),
        .din        (din),
        .hs_enable  (hs_enable),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .sync_found (sync_found),
        .aligned    (aligned),
        .phase      (phase),
        .sync_err   (sync_err)
    );

    always #5 dphy_clk = ~dphy_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: raw received-bit history plus edge stamps for each mode change.
    int   k = 0;
    int   mode = M_IDLE;
    int   settle_start, hunt_start, lock_edge;
    bit   m_phase;
    bit   hist[$];
    logic [7:0] e_byte = '0;
    bit   e_valid = 0, e_sync = 0, e_aligned = 0, e_phase = 0, e_err = 0;

    logic [7:0] obs_byte[$];
    int         obs_edge[$];
    int         n_sync = 0, n_err = 0, last_err_edge = -1;

    bit txq[$];

    function automatic logic [7:0] take(int start);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = hist[start + i];
        return v;
    endfunction

    function automatic bit is_sync(logic [7:0] c);
`ifdef DPHY_ALIGN_SYNC_TOL_EN
        return $countones(c ^ SYNC) <= 1;
`else
        return c == SYNC;
`endif
    endfunction

    task automatic model_step();
        logic [7:0] ce, co;
        if (areset) begin
            k = 0;
            mode = M_IDLE;
            m_phase = 0;
            hist.delete();
            for (int i = 0; i < 9; i++) hist.push_back(1'b0);
            e_byte = '0; e_valid = 0; e_sync = 0; e_aligned = 0; e_phase = 0; e_err = 0;
            return;
        end
        k++;
        ce = take(hist.size() - 8);
        co = take(hist.size() - 9);
        e_valid = 0; e_sync = 0; e_err = 0;
        if (!hs_enable) begin
            mode = M_IDLE;
            m_phase = 0;
        end else begin
            case (mode)
                M_IDLE: begin mode = M_SETTLE; settle_start = k; end
                M_SETTLE: if (k - settle_start == SETTLE_CYCLES) begin mode = M_HUNT; hunt_start = k; end
                M_HUNT: begin
                    if (is_sync(ce) || is_sync(co)) begin
                        m_phase = !is_sync(ce);
                        e_byte = SYNC; e_valid = 1; e_sync = 1;
                        mode = M_LOCKED; lock_edge = k;
                    end else if (k - hunt_start == TIMEOUT_CYCLES) begin
                        e_err = 1; mode = M_STUCK;
                    end
                end
                M_LOCKED: if ((k - lock_edge) % 4 == 0) begin
                    e_byte = m_phase ? co : ce; e_valid = 1;
                end
                default: ;
            endcase
        end
        e_aligned = (mode == M_LOCKED);
        e_phase = m_phase;
        hist.push_back(din[0]);
        hist.push_back(din[1]);
        while (hist.size() > 9) void'(hist.pop_front());
    endtask

    initial forever begin
        @(posedge dphy_clk or posedge areset);
        model_step();
    end

    task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s edge %0d: got %h want %h", name, k, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s edge %0d: got %b want %b", name, k, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, plus logging of strobes and pulses.
    initial forever begin
        @(negedge dphy_clk);
        chk8("byte_out", byte_out, e_byte);
        chk1("byte_valid", byte_valid, e_valid);
        chk1("sync_found", sync_found, e_sync);
        chk1("aligned", aligned, e_aligned);
        chk1("phase", phase, e_phase);
        chk1("sync_err", sync_err, e_err);
        if (byte_valid) begin
            obs_byte.push_back(byte_out);
            obs_edge.push_back(k);
            $display("strobe edge %0d byte %h sync %b phase %b", k, byte_out, sync_found, phase);
        end
        if (sync_found) n_sync++;
        if (sync_err) begin
            n_err++;
            last_err_edge = k;
            $display("sync_err edge %0d", k);
        end
    end

    task automatic step(bit b0, bit b1, bit en);
        @(negedge dphy_clk);
        #1;
        din = {b1, b0};
        hs_enable = en;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic q_byte(logic [7:0] v);
        for (int i = 0; i < 8; i++) txq.push_back(v[i]);
    endtask

    task automatic q_zeros(int n);
        repeat (n) txq.push_back(1'b0);
    endtask

    // Plays the queued bits with hs_enable high; returns the edge that samples the first pair.
    task automatic play(output int first_edge);
        bit b0, b1;
        first_edge = -1;
        if (txq.size() % 2 != 0) txq.push_back(1'b0);
        while (txq.size() >= 2) begin
            b0 = txq.pop_front();
            b1 = txq.pop_front();
            step(b0, b1, 1'b1);
            if (first_edge < 0) first_edge = k + 1;
        end
    endtask

    task automatic locked_stream(int lead_zeros, output int base, output int e0);
        base = obs_byte.size();
        q_zeros(lead_zeros);
        q_byte(8'hB8); q_byte(8'h12); q_byte(8'h34);
        q_zeros(16);
        play(e0);
    endtask

    initial begin
        int base, e0, s_base, e_base, strobes_before;
        bit seen;
        areset = 1'b0;
        din = 2'b00;
        hs_enable = 1'b0;
        #2 areset = 1'b1;
        repeat (3) @(negedge dphy_clk);
        chk8("reset_byte_out", byte_out, 8'h00);
        chk1("reset_aligned", aligned, 1'b0);
        chk1("reset_valid", byte_valid, 1'b0);
        #1 areset = 1'b0;
        idle(2);

        // Even phase: sync final bit on din[1] at pair 13 -> strobe at E+14.
        s_base = n_sync;
        locked_stream(20, base, e0);
        @(negedge dphy_clk);
        chk8("even_b0", obs_byte[base], 8'hB8);
        chk8("even_b1", obs_byte[base + 1], 8'h12);
        chk8("even_b2", obs_byte[base + 2], 8'h34);
        chk_int("even_first_edge", obs_edge[base], e0 + 14);
        chk_int("even_gap1", obs_edge[base + 1] - obs_edge[base], 4);
        chk_int("even_gap2", obs_edge[base + 2] - obs_edge[base + 1], 4);
        chk_int("even_sync_count", n_sync - s_base, 1);
        chk1("even_phase", phase, 1'b0);
        chk1("even_aligned", aligned, 1'b1);

        // Odd phase: one extra leading bit shifts the sync end onto din[0].
        idle(3);
        s_base = n_sync;
        locked_stream(21, base, e0);
        @(negedge dphy_clk);
        chk8("odd_b0", obs_byte[base], 8'hB8);
        chk8("odd_b1", obs_byte[base + 1], 8'h12);
        chk8("odd_b2", obs_byte[base + 2], 8'h34);
        chk_int("odd_first_edge", obs_edge[base], e0 + 15);
        chk_int("odd_sync_count", n_sync - s_base, 1);
        chk1("odd_phase", phase, 1'b1);

        // Sync byte inside the settle window must be ignored; hunt then times out.
        idle(3);
        base = obs_byte.size();
        e_base = n_err;
        q_byte(8'hB8);
        q_zeros(150);
        play(e0);
        chk_int("settle_no_strobe", obs_byte.size() - base, 0);
        chk_int("timeout_err_count", n_err - e_base, 1);
        chk_int("timeout_err_edge", last_err_edge, e0 + SETTLE_CYCLES + TIMEOUT_CYCLES);
        chk1("timeout_aligned", aligned, 1'b0);

        // Mid-byte exit two cycles after the second strobe.
        idle(3);
        base = obs_byte.size();
        q_zeros(20);
        q_byte(8'hB8); q_byte(8'h12); q_byte(8'h34); q_byte(8'h56);
        q_zeros(16);
        seen = 0;
        while (txq.size() >= 2 && !seen) begin
            bit b0, b1;
            b0 = txq.pop_front();
            b1 = txq.pop_front();
            step(b0, b1, 1'b1);
            if (obs_byte.size() >= base + 2) seen = 1;
        end
        txq.delete();
        chk1("exit_strobe_seen", seen, 1'b1);
        strobes_before = obs_byte.size();
        step(1'b0, 1'b0, 1'b0);
        @(negedge dphy_clk);
        chk1("exit_aligned", aligned, 1'b0);
        chk1("exit_valid", byte_valid, 1'b0);
        idle(10);
        chk_int("exit_no_more_strobes", obs_byte.size(), strobes_before);

        // Re-entry with the odd stream.
        locked_stream(21, base, e0);
        @(negedge dphy_clk);
        chk8("reentry_b0", obs_byte[base], 8'hB8);
        chk1("reentry_phase", phase, 1'b1);

        // Sync byte with one bit wrong.
        idle(3);
        base = obs_byte.size();
        s_base = n_sync;
        e_base = n_err;
        q_zeros(20);
        q_byte(8'hB9);
        q_zeros(160);
        play(e0);
`ifdef DPHY_ALIGN_SYNC_TOL_EN
        chk_int("tol_sync_count", n_sync - s_base, 1);
        chk8("tol_byte", obs_byte[base], 8'hB8);
`else
        chk_int("tol_no_strobe", obs_byte.size() - base, 0);
        chk_int("tol_err_count", n_err - e_base, 1);
`endif

        // Reset while locked.
        idle(3);
        locked_stream(20, base, e0);
        chk1("pre_reset_aligned", aligned, 1'b1);
        @(negedge dphy_clk);
        #2 areset = 1'b1;
        #1;
        chk8("areset_byte_out", byte_out, 8'h00);
        chk1("areset_valid", byte_valid, 1'b0);
        chk1("areset_sync", sync_found, 1'b0);
        chk1("areset_aligned", aligned, 1'b0);
        chk1("areset_phase", phase, 1'b0);
        chk1("areset_err", sync_err, 1'b0);
        @(negedge dphy_clk);
        #1 areset = 1'b0;
        base = obs_byte.size();
        repeat (12) step(1'b0, 1'b0, 1'b1);
        chk1("post_reset_aligned", aligned, 1'b0);
        chk_int("post_reset_no_strobe", obs_byte.size() - base, 0);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dphy_lane_aligner.md
# dphy_lane_aligner

Per-lane D-PHY HS byte aligner in the fast `dphy_clk` domain. It sits directly after the architecture DDR input primitive and consumes its 2-bit-per-clock stream. It hunts for the HS sync byte at either bit phase, then emits LSB-first-aligned bytes with a valid strobe every 4 `dphy_clk` cycles. The sys_clk crossing is done downstream.

## Interface
- `SETTLE_CYCLES`, 4: `dphy_clk` cycles after `hs_enable` rises during which the stream is ignored (HS-settle).
- `TIMEOUT_CYCLES`, 64: maximum HUNT duration before `sync_err`.
- `dphy_clk` in 1: fast D-PHY DDR clock.
- `areset` in 1: asynchronous, active-high reset.
- `din` in 2: bits from the DDR primitive. `din[0]` is earlier, `din[1]` is later.
- `hs_enable` in 1: lane in HS mode. Already synchronous to `dphy_clk`.
- `byte_out` out 8: aligned byte, LSB = first received bit.
- `byte_valid` out 1: one-cycle strobe qualifying `byte_out`.
- `sync_found` out 1: one-cycle pulse, coincident with the `byte_valid` that carries the sync byte.
- `aligned` out 1: level, high while in LOCKED.
- `phase` out 1: latched bit phase (0 = even, 1 = odd).
- `sync_err` out 1: one-cycle pulse on HUNT timeout.

## Operation
- Clock is `dphy_clk`. Reset is `areset`, asynchronous, active-high. On reset, every output, the shift register and the counters are 0, and the state is IDLE.
- Shift register `sr[8:0]` updates every cycle with `sr <= {din[1], din[0], sr[8:2]}`.
- There are two candidates:
  - even: `sr[8:1]`, whose last bit is `din[1]`;
  - odd: `sr[7:0]`, whose last bit is `din[0]`.
- A candidate matches when it equals `SYNC_BYTE` = 8'hB8.
- FSM states and transitions:
  - IDLE: counters cleared. If `hs_enable`=1, go to SETTLE.
  - SETTLE: count `SETTLE_CYCLES`, ignoring matches, then go to HUNT.
  - HUNT: on a match, latch `phase` (even wins if both match), clear the 2-bit byte counter, emit the matched byte with `byte_valid`+`sync_found`, then go to LOCKED. If the HUNT counter reaches `TIMEOUT_CYCLES`-1 with no match, pulse `sync_err` and go to FAIL.
  - LOCKED: the byte counter increments every cycle. When it wraps to 0, emit the candidate selected by `phase` with `byte_valid`.
  - FAIL: no output; stay until `hs_enable`=0.
- `hs_enable`=0 in any state moves to IDLE on the next edge, which takes priority over every other transition. A partial byte is discarded, and `aligned`, `byte_valid` and `phase` are cleared.
- In LOCKED, a data byte equal to 8'hB8 is ordinary data and never re-triggers `sync_found`.
- Counter widths are `$clog2` of the respective parameter (minimum 1). The HUNT counter saturates and does not wrap.

## Timing
- Let edge N be the edge that loads the final sync bit into `sr`. At edge N+1, `byte_out`=8'hB8, `byte_valid`=1, `sync_found`=1, `aligned`=1.
- Subsequent bytes appear at edges N+5, N+9, … (every 4 cycles).
- `byte_out` holds its last value between strobes.
- `hs_enable` falling sampled at edge M: at M, outputs `byte_valid` and `aligned` are 0 and the state is IDLE. No strobe occurs at or after M.
- `sync_err` asserts at the edge that completes `TIMEOUT_CYCLES` HUNT cycles.

## Configuration
- `DPHY_ALIGN_SYNC_TOL_EN` defined: a candidate also matches at Hamming distance 1 from 8'hB8 (single-bit sync error tolerance). `byte_out` for the sync byte is then forced to 8'hB8.
- Not defined: exact match only.

## Structure
- Shared package `dphy_pkg` holds:
  - `SYNC_BYTE` (8'hB8);
  - the `align_state_t` enum (IDLE, SETTLE, HUNT, LOCKED, FAIL).
- Sub-module `dphy_sync_match`: combinational, 8-bit candidate in, match out. It implements exact/tolerant compare under the macro and is instantiated twice (even and odd).

## Test plan
- Even phase: after settle, send zeros, then 8'hB8, 8'h12, 8'h34 LSB-first aligned to `din[0]`. Required: strobes 4 cycles apart with B8, 12, 34; one `sync_found`; `phase`=0.
- Odd phase: same stream preceded by one extra 0 bit. Required: identical bytes; `phase`=1.
- Settle/timeout: send 8'hB8 inside the settle window, then zeros for 64 cycles. Required: no lock, one `sync_err` pulse, then silence until `hs_enable` toggles.
- Mid-byte exit: drop `hs_enable` 2 cycles after a strobe. Required: no further `byte_valid`, `aligned`=0 at the sampling edge. Re-entry with the odd-phase stream relocks with `phase`=1.
- Tolerance: send 8'hB9 as sync. With `DPHY_ALIGN_SYNC_TOL_EN`: lock, `byte_out`=8'hB8. Without it: no lock, `sync_err` fires.
- Reset: assert `areset` while LOCKED. Required: all outputs 0 immediately; IDLE after release.
